// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
// Module   : data_memory
// Brief    : Single-port word memory with valid/ready requests, a fixed-depth
//            read pipeline, out-of-range flagging and a committed-write count.
// Revision : 1.0
// ============================================================================
module data_memory #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 1,
  parameter int PIPELINED    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  output logic                  error_flag,
  output logic [15:0]           write_count
);

  localparam int c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH + 1)'(DEPTH);
  localparam int c_last = READ_LATENCY - 1;
  // Stage that feeds the output register; only meaningful when latency > 1.
  localparam int c_pre  = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic                    r_ready;
  logic [15:0]             r_wcnt;
  logic                    r_err_flag;
  logic [READ_LATENCY-1:0] r_pv;
  logic [READ_LATENCY-1:0] r_pe;
  logic [DATA_WIDTH-1:0]   r_pd [READ_LATENCY];

  logic               w_accept;
  logic               w_wr_acc;
  logic               w_rd_acc;
  logic               w_in_range;
  logic [c_idx_w-1:0] w_idx;

  assign w_accept   = req_valid & r_ready;
  assign w_wr_acc   = w_accept & req_write;
  assign w_rd_acc   = w_accept & ~req_write;
  assign w_in_range = ({1'b0, req_addr} < c_depth);
  assign w_idx      = req_addr[c_idx_w-1:0];

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc && w_in_range) begin
      r_mem[w_idx] <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wcnt     <= 16'd0;
      r_err_flag <= 1'b0;
    end else begin
      if (w_wr_acc && w_in_range) begin
        r_wcnt <= r_wcnt + 16'd1;
      end
      if (w_accept && !w_in_range) begin
        r_err_flag <= 1'b1;
      end
    end
  end

  // Data is zeroed at entry for misses and errors, so the output stage
  // already reads 0 whenever no good response is present.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pv <= '0;
      r_pe <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_pd[i] <= '0;
      end
    end else begin
      r_pv[0] <= w_rd_acc;
      r_pe[0] <= w_rd_acc & ~w_in_range;
      r_pd[0] <= (w_rd_acc && w_in_range) ? r_mem[w_idx] : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pe[i] <= r_pe[i-1];
        r_pd[i] <= r_pd[i-1];
      end
    end
  end

  generate
    if (PIPELINED != 0) begin : g_pipelined
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_ready <= 1'b0;
        end else begin
          r_ready <= 1'b1;
        end
      end
    end else begin : g_single
      state_t r_state;

      // Ready is restored on the edge that loads the output stage, so the
      // next read can be taken in the same cycle the response is shown.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
        end else begin
          case (r_state)
            ST_IDLE: begin
              r_ready <= 1'b1;
              if (w_rd_acc && (READ_LATENCY > 1)) begin
                r_state <= ST_WAIT;
                r_ready <= 1'b0;
              end
            end
            ST_WAIT: begin
              if (r_pv[c_pre]) begin
                r_state <= ST_IDLE;
                r_ready <= 1'b1;
              end
            end
            default: begin
              r_state <= ST_IDLE;
              r_ready <= 1'b0;
            end
          endcase
        end
      end
    end
  endgenerate

  assign req_ready   = r_ready;
  assign resp_valid  = r_pv[c_last];
  assign resp_error  = r_pe[c_last];
  assign resp_rdata  = r_pd[c_last];
  assign error_flag  = r_err_flag;
  assign write_count = r_wcnt;

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory
// Brief    : Scoreboard bench for data_memory across three configurations.
// Revision : 1.0
// ============================================================================
module tb_data_memory;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req_valid_a  [3];
  logic        req_write_a  [3];
  logic [7:0]  req_addr_a   [3];
  logic [15:0] req_wdata_a  [3];
  logic        req_ready_a  [3];
  logic        resp_valid_a [3];
  logic [15:0] resp_rdata_a [3];
  logic        resp_error_a [3];
  logic        error_flag_a [3];
  logic [15:0] wcnt_a       [3];

  localparam int LAT [3] = '{1, 3, 3};

  // dut0: DEPTH=200, latency 1; dut1: latency 3 streaming; dut2: latency 3 single.
  data_memory #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(200), .READ_LATENCY(1), .PIPELINED(1)) u_dut0 (
    .clk(clk), .reset(rst_n), .req_valid(req_valid_a[0]), .req_ready(req_ready_a[0]),
    .req_write(req_write_a[0]), .req_addr(req_addr_a[0]), .req_wdata(req_wdata_a[0]),
    .resp_valid(resp_valid_a[0]), .resp_rdata(resp_rdata_a[0]), .resp_error(resp_error_a[0]),
    .error_flag(error_flag_a[0]), .write_count(wcnt_a[0]));

  data_memory #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(256), .READ_LATENCY(3), .PIPELINED(1)) u_dut1 (
    .clk(clk), .reset(rst_n), .req_valid(req_valid_a[1]), .req_ready(req_ready_a[1]),
    .req_write(req_write_a[1]), .req_addr(req_addr_a[1]), .req_wdata(req_wdata_a[1]),
    .resp_valid(resp_valid_a[1]), .resp_rdata(resp_rdata_a[1]), .resp_error(resp_error_a[1]),
    .error_flag(error_flag_a[1]), .write_count(wcnt_a[1]));

  data_memory #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(256), .READ_LATENCY(3), .PIPELINED(0)) u_dut2 (
    .clk(clk), .reset(rst_n), .req_valid(req_valid_a[2]), .req_ready(req_ready_a[2]),
    .req_write(req_write_a[2]), .req_addr(req_addr_a[2]), .req_wdata(req_wdata_a[2]),
    .resp_valid(resp_valid_a[2]), .resp_rdata(resp_rdata_a[2]), .resp_error(resp_error_a[2]),
    .error_flag(error_flag_a[2]), .write_count(wcnt_a[2]));

  typedef struct {
    int          stamp;
    logic        err;
    logic [15:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int k, input int stamp, input logic err, input logic [15:0] data);
    exp_t e;
    e.stamp = stamp;
    e.err   = err;
    e.data  = data;
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic check_resp(input int k);
    exp_t e;
    logic have;
    have = 1'b0;
    case (k)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_resp dut%0d: got resp_valid=1 expected none (cyc=%0d)", k, cyc);
    end else begin
      chk($sformatf("resp_cycle dut%0d", k), cyc, e.stamp);
      chk($sformatf("resp_rdata dut%0d", k), {16'd0, resp_rdata_a[k]}, {16'd0, e.data});
      chk($sformatf("resp_error dut%0d", k), {31'd0, resp_error_a[k]}, {31'd0, e.err});
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (resp_valid_a[k] === 1'b1) check_resp(k);
    end
  end

  task automatic idle(input int k);
    req_valid_a[k] = 1'b0;
    req_write_a[k] = 1'b0;
  endtask

  // Called 1 time unit after a rising edge; returns the same way after acceptance.
  task automatic do_req(input int k, input logic wr, input logic [7:0] a, input logic [15:0] d,
                        output int acc, output int stalls);
    logic rdy;
    req_valid_a[k] = 1'b1;
    req_write_a[k] = wr;
    req_addr_a[k]  = a;
    req_wdata_a[k] = d;
    acc    = -1;
    stalls = 0;
    for (int n = 0; n < 32; n++) begin
      rdy = req_ready_a[k];
      @(posedge clk);
      #1;
      if (rdy === 1'b1) begin
        acc = cyc;
        break;
      end
      stalls++;
    end
    if (acc < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout dut%0d: got no accept expected accept within 32 cycles", k);
    end
  endtask

  task automatic rd(input int k, input logic [7:0] a, input logic err, input logic [15:0] d);
    int acc, st;
    do_req(k, 1'b0, a, 16'd0, acc, st);
    push(k, acc + LAT[k] - 1, err, d);
  endtask

  task automatic wr(input int k, input logic [7:0] a, input logic [15:0] d);
    int acc, st;
    do_req(k, 1'b1, a, d, acc, st);
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_ready dut%0d", k), {31'd0, req_ready_a[k]}, 32'd0);
      chk($sformatf("rst_resp_valid dut%0d", k), {31'd0, resp_valid_a[k]}, 32'd0);
      chk($sformatf("rst_rdata dut%0d", k), {16'd0, resp_rdata_a[k]}, 32'd0);
      chk($sformatf("rst_resp_error dut%0d", k), {31'd0, resp_error_a[k]}, 32'd0);
      chk($sformatf("rst_error_flag dut%0d", k), {31'd0, error_flag_a[k]}, 32'd0);
      chk($sformatf("rst_write_count dut%0d", k), {16'd0, wcnt_a[k]}, 32'd0);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, acc1, acc2, st, prev;
    for (int k = 0; k < 3; k++) begin
      idle(k);
      req_addr_a[k]  = 8'd0;
      req_wdata_a[k] = 16'd0;
    end

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("ready_after_release dut%0d", k), {31'd0, req_ready_a[k]}, 32'd1);

    // Basic write/read, read-after-write, latency 1
    wr(0, 8'h10, 16'hBEEF);
    chk("write_count_after_first", {16'd0, wcnt_a[0]}, 32'd1);
    rd(0, 8'h10, 1'b0, 16'hBEEF);
    wr(0, 8'h11, 16'h5555);
    rd(0, 8'h11, 1'b0, 16'h5555);
    chk("write_count_after_raw", {16'd0, wcnt_a[0]}, 32'd2);
    chk("error_flag_clean", {31'd0, error_flag_a[0]}, 32'd0);

    // Out of range with DEPTH=200
    wr(0, 8'hC8, 16'h1234);
    chk("oor_write_count", {16'd0, wcnt_a[0]}, 32'd2);
    chk("oor_error_flag", {31'd0, error_flag_a[0]}, 32'd1);
    rd(0, 8'hFF, 1'b1, 16'h0000);
    wr(0, 8'hC7, 16'hABCD);
    chk("last_word_write_count", {16'd0, wcnt_a[0]}, 32'd3);
    rd(0, 8'hC7, 1'b0, 16'hABCD);
    rd(0, 8'hC8, 1'b1, 16'h0000);
    idle(0);

    // Pipelined streaming, latency 3
    for (int i = 0; i < 4; i++) wr(1, 8'(i), 16'(16'hA0 + i));
    wr(1, 8'h30, 16'h7777);
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      do_req(1, 1'b0, 8'(i), 16'd0, acc, st);
      push(1, acc + 2, 1'b0, 16'(16'hA0 + i));
      chk($sformatf("stream_stall %0d", i), st, 0);
      if (i > 0) chk($sformatf("stream_accept_gap %0d", i), acc - prev, 1);
      prev = acc;
    end
    idle(1);
    chk("stream_write_count", {16'd0, wcnt_a[1]}, 32'd5);
    drain(6);

    // Single-outstanding mode, latency 3
    wr(2, 8'h20, 16'h1111);
    wr(2, 8'h21, 16'h2222);
    do_req(2, 1'b0, 8'h20, 16'd0, acc1, st);
    push(2, acc1 + 2, 1'b0, 16'h1111);
    chk("single_first_stall", st, 0);
    do_req(2, 1'b0, 8'h21, 16'd0, acc2, st);
    push(2, acc2 + 2, 1'b0, 16'h2222);
    chk("single_second_stall", st, 2);
    chk("single_accept_gap", acc2 - acc1, 3);
    idle(2);
    drain(6);

    // Reset while a read is in flight: its response must never appear
    chk("queues_empty_before_reset", q0.size() + q1.size() + q2.size(), 0);
    do_req(1, 1'b0, 8'h30, 16'd0, acc, st);
    idle(1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_midread_reset", {31'd0, req_ready_a[1]}, 32'd1);
    drain(4);
    rd(1, 8'h30, 1'b0, 16'h7777);
    idle(1);
    rd(0, 8'h10, 1'b0, 16'hBEEF);
    idle(0);
    drain(6);

    // Write counter wrap
    chk("wrap_start", {16'd0, wcnt_a[0]}, 32'd0);
    for (int i = 0; i < 65536; i++) wr(0, 8'(i % 200), 16'(i));
    idle(0);
    chk("wrap_to_zero", {16'd0, wcnt_a[0]}, 32'd0);
    wr(0, 8'h05, 16'h0001);
    idle(0);
    chk("wrap_plus_one", {16'd0, wcnt_a[0]}, 32'd1);

    drain(8);
    chk("dut0_missing_responses", q0.size(), 0);
    chk("dut1_missing_responses", q1.size(), 0);
    chk("dut2_missing_responses", q2.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
